id_stage_ctrl: RTL and testbench
================================

ID_STAGE_CTRL -- requirements
Module: id_stage_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-003 SHALL have ports if_valid in 1, if_inst in 32, if_pc in 32: fetch offer.
REQ-004 SHALL have port if_ready  out  1  fetch accept; transfer when if_valid & if_ready.
REQ-005 SHALL have ports ex_memread in 1, ex_rd in 5: load currently in EX and its destination.
REQ-006 SHALL have port flush  in  1  taken branch/jump redirect from EX.
REQ-007 SHALL have port ex_ready  in  1  EX accepts ID output this cycle.
REQ-008 SHALL have ports id_valid out 1, id_inst out 32, id_pc out 32: decode-stage instruction to immgen/regfile/EX.
REQ-009 SHALL have port imm_sel  out  3  immediate format of id_inst: 0 NONE, 1 U, 2 J, 3 I, 4 B, 5 S, 6 SHAMT.
REQ-010 SHALL have port id_stall  out  1  high during a load-use bubble cycle.

Function
REQ-011 SHALL buffer fetched instructions in a 2-entry FIFO {inst,pc} feeding one ID register; total capacity 3.
REQ-012 SHALL drive if_ready = FIFO not full (registered count, not dependent on if_valid).
REQ-013 SHALL load the ID register from FIFO head (or directly from fetch if FIFO empty, same cycle push-through forbidden: minimum 1 cycle fetch-to-ID latency) when ID state EMPTY or ID fires.
REQ-014 SHALL implement ID states EMPTY, FULL, STALL; EMPTY->FULL on load; FULL->EMPTY on fire with nothing to load; FULL->FULL on fire with reload; FULL->STALL on hazard; STALL->FULL unconditionally after one cycle.
REQ-015 SHALL define hazard = FULL & ex_memread & ex_rd!=0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
REQ-016 SHALL set uses_rs1 for I, B, S, SHAMT, R (opcode 0110011) formats; uses_rs2 for B, S, R; U and J use neither.
REQ-017 SHALL drive id_valid = (state FULL | STALL-exit) & ~hazard; id_stall = hazard in FULL; during stall id_inst/id_pc held, id_valid=0 (bubble).
REQ-018 SHALL ignore hazard in STALL state (load has left EX; forwarding covers it).
REQ-019 SHALL fire ID when id_valid & ex_ready; ex_ready low holds ID register and all outputs stable.
REQ-020 SHALL decode imm_sel combinationally from id_inst opcode/funct3/funct7 using same format classes as the immediate generator; unknown opcode -> 0.
REQ-021 SHALL, on flush, clear FIFO and ID register next edge (state EMPTY, count 0); flush overrides same-cycle push, fire and hazard.
REQ-022 SHALL support simultaneous push and pop at FIFO full (count unchanged); pointers wrap mod 2.

Reset
REQ-023 SHALL on rst: state EMPTY, FIFO count 0, pointers 0, id_inst 32'h00000013 (nop), id_pc 0.
REQ-024 SHALL while rst high: id_valid 0, id_stall 0, if_ready 0, imm_sel 3 (nop is I-type); if_ready 1 first cycle after release.

Structure
REQ-025 SHALL place opcode constants, imm_sel encodings and state encoding in shared package id_pkg.
REQ-026 SHALL implement the FIFO as sub-module inst_fifo2 (push/pop/full/empty/count).

Verification
REQ-027 SHALL test: ID holds 0x00128333 (add x6,x5,x1), ex_memread=1, ex_rd=5 -> id_stall=1, id_valid=0 one cycle, then id_valid=1 same inst.
REQ-028 SHALL test: ID holds 0x123452B7 (lui x5), ex_memread=1, ex_rd=5 -> no stall, imm_sel=1.
REQ-029 SHALL test: ex_ready=0, push 4 instructions -> 3 accepted, if_ready=0 after third, order preserved on drain.
REQ-030 SHALL test: FIFO full + ID FULL, flush=1 with if_valid=1 -> next cycle id_valid=0, count 0, if_ready=1, pushed inst dropped.
REQ-031 SHALL test: rst asserted mid-stall -> outputs reach REQ-023/024 values asynchronously before next edge.
REQ-032 SHALL test: ex_rd=0 with matching rs1=0 load -> no stall.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode-stage types: opcode constants, immediate formats, ID state encoding,
// and the format-class helpers used by both immgen selection and hazard detection.
package id_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RAW  = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SRX  = 3'b101;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_U     = 3'd1,
    IMM_J     = 3'd2,
    IMM_I     = 3'd3,
    IMM_B     = 3'd4,
    IMM_S     = 3'd5,
    IMM_SHAMT = 3'd6
  } imm_sel_e;

  typedef enum logic [1:0] {
    ID_EMPTY = 2'd0,
    ID_FULL  = 2'd1,
    ID_STALL = 2'd2
  } id_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_t;

  localparam fetch_t NOP_ENTRY = '{inst: NOP_INST, pc: '0};

  // Shift-immediates with an illegal funct7 fall back to NONE like any unknown encoding.
  function automatic imm_sel_e imm_fmt(input logic [6:0] opcode,
                                       input logic [2:0] funct3,
                                       input logic [6:0] funct7);
    imm_sel_e fmt;
    fmt = IMM_NONE;
    case (opcode)
      OPC_LUI, OPC_AUIPC:           fmt = IMM_U;
      OPC_JAL:                      fmt = IMM_J;
      OPC_JALR, OPC_LOAD:           fmt = IMM_I;
      OPC_BRANCH:                   fmt = IMM_B;
      OPC_STORE:                    fmt = IMM_S;
      OPC_OPIMM: begin
        if (funct3 == F3_SLL)
          fmt = (funct7 == F7_BASE) ? IMM_SHAMT : IMM_NONE;
        else if (funct3 == F3_SRX)
          fmt = (funct7 == F7_BASE || funct7 == F7_ALT) ? IMM_SHAMT : IMM_NONE;
        else
          fmt = IMM_I;
      end
      default:                      fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opcode, input imm_sel_e fmt);
    return (fmt == IMM_I) || (fmt == IMM_B) || (fmt == IMM_S) ||
           (fmt == IMM_SHAMT) || (opcode == OPC_OP);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode, input imm_sel_e fmt);
    return (fmt == IMM_B) || (fmt == IMM_S) || (opcode == OPC_OP);
  endfunction

endpackage

// File: rtl/id_stage_ctrl_if.sv
// Fetch -> ID -> EX handshake bundle; master is the surrounding pipeline, slave is the ID stage.
interface id_stage_ctrl_if;
  import id_pkg::*;

  logic            if_valid;
  logic [XLEN-1:0] if_inst;
  logic [XLEN-1:0] if_pc;
  logic            if_ready;
  logic            ex_memread;
  logic [RAW-1:0]  ex_rd;
  logic            flush;
  logic            ex_ready;
  logic            id_valid;
  logic [XLEN-1:0] id_inst;
  logic [XLEN-1:0] id_pc;
  logic [2:0]      imm_sel;
  logic            id_stall;

  modport master (
    output if_valid, if_inst, if_pc, ex_memread, ex_rd, flush, ex_ready,
    input  if_ready, id_valid, id_inst, id_pc, imm_sel, id_stall
  );

  modport slave (
    input  if_valid, if_inst, if_pc, ex_memread, ex_rd, flush, ex_ready,
    output if_ready, id_valid, id_inst, id_pc, imm_sel, id_stall
  );

endinterface

// File: rtl/inst_fifo2.sv
// Two-entry {inst,pc} skid FIFO in front of the ID register; clr empties it on redirect.
module inst_fifo2 import id_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  fetch_t     din,
  output fetch_t     dout,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  localparam int unsigned DEPTH = 2;

  fetch_t     mem [DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt_q;
  logic       do_push;
  logic       do_pop;

  // A push at full is legal only when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop & (cnt_q != 2'd0);
    do_push = push & ((cnt_q != 2'(DEPTH)) | do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else if (clr) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt_q == 2'(DEPTH));
  assign empty = (cnt_q == 2'd0);
  assign count = cnt_q;

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage control: fetch buffering, ID register with load-use stall, flush and
// immediate-format selection for the immediate generator.
module id_stage_ctrl import id_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  id_stage_ctrl_if.slave  bus
);

  id_state_e  state;
  fetch_t     id_q;
  logic       live_q;

  fetch_t     fetch_in;
  fetch_t     fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic [1:0] fifo_count;
  logic       fifo_push;
  logic       fifo_pop;

  imm_sel_e       fmt;
  logic [RAW-1:0] rs1;
  logic [RAW-1:0] rs2;
  logic           hazard;
  logic           id_valid;
  logic           if_ready;
  logic           xfer;
  logic           fire;
  logic           slot_free;
  logic           take_head;
  logic           take_fetch;

  assign fetch_in = '{inst: bus.if_inst, pc: bus.if_pc};

  // live_q keeps fetch closed for the whole reset and opens it on the first edge after.
  assign if_ready = live_q & ~fifo_full;

  always_comb begin
    fmt = imm_fmt(id_q.inst[6:0], id_q.inst[14:12], id_q.inst[31:25]);
    rs1 = id_q.inst[19:15];
    rs2 = id_q.inst[24:20];

    hazard = (state == ID_FULL) & bus.ex_memread & (bus.ex_rd != '0) &
             ((uses_rs1(id_q.inst[6:0], fmt) & (rs1 == bus.ex_rd)) |
              (uses_rs2(id_q.inst[6:0], fmt) & (rs2 == bus.ex_rd)));

    id_valid   = ((state == ID_FULL) | (state == ID_STALL)) & ~hazard;
    fire       = id_valid & bus.ex_ready;
    xfer       = bus.if_valid & if_ready;
    slot_free  = (state == ID_EMPTY) | fire;

    // Head of the FIFO has priority; fetch goes straight into ID only when nothing is queued.
    take_head  = slot_free & ~fifo_empty;
    take_fetch = slot_free & fifo_empty & xfer;

    fifo_pop   = take_head & ~bus.flush;
    fifo_push  = xfer & ~take_fetch & ~bus.flush;
  end

  inst_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fetch_in),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ID register and state; flush wins over load, fire and hazard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ID_EMPTY;
      id_q   <= NOP_ENTRY;
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (bus.flush) begin
        state <= ID_EMPTY;
        id_q  <= NOP_ENTRY;
      end else if (take_head) begin
        state <= ID_FULL;
        id_q  <= fifo_head;
      end else if (take_fetch) begin
        state <= ID_FULL;
        id_q  <= fetch_in;
      end else if (fire) begin
        state <= ID_EMPTY;
      end else if (hazard) begin
        state <= ID_STALL;
      end else if (state == ID_STALL) begin
        state <= ID_FULL;
      end
    end
  end

  fifo_count_a: assert property (@(posedge clk) disable iff (rst)
                                 fifo_full == (fifo_count == 2'd2));

  assign bus.if_ready = if_ready;
  assign bus.id_valid = id_valid;
  assign bus.id_stall = hazard;
  assign bus.id_inst  = id_q.inst;
  assign bus.id_pc    = id_q.pc;
  assign bus.imm_sel  = 3'(fmt);

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Scoreboard bench for id_stage_ctrl: accepted fetches are queued with their expected
// immediate format and compared in order as ID hands them to EX.
module tb_id_stage_ctrl;
  import id_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_ctrl_if bus ();

  id_stage_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  imm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [2:0] cur_imm;

  // addi, lui, sw, jal, beq, add, slli, lw, auipc, jalr, ecall, srai
  logic [31:0] t_inst [12] = '{32'h00500093, 32'h123452B7, 32'h0020A223, 32'h008000EF,
                               32'h00708463, 32'h00128333, 32'h00209293, 32'h0000A103,
                               32'h00000017, 32'h00008067, 32'h00000073, 32'h4010D293};
  logic [2:0]  t_imm  [12] = '{3'd3, 3'd1, 3'd5, 3'd2, 3'd4, 3'd0, 3'd6, 3'd3,
                               3'd1, 3'd3, 3'd0, 3'd6};

  // Load-use table: table index of the ID instruction, EX load destination, stall expected.
  int          hz_idx [6] = '{5, 4, 1, 0, 7, 2};
  logic [4:0]  hz_rd  [6] = '{5'd5, 5'd7, 5'd5, 5'd0, 5'd1, 5'd2};
  logic        hz_st  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_valid   = 1'b0;
    bus.flush      = 1'b0;
    bus.ex_memread = 1'b0;
    bus.ex_rd      = 5'd0;
    bus.ex_ready   = 1'b0;
  endtask

  task automatic offer(input int k, input logic [31:0] pc);
    bus.if_valid = 1'b1;
    bus.if_inst  = t_inst[k];
    bus.if_pc    = pc;
    cur_imm      = t_imm[k];
  endtask

  task automatic drain(input int budget, input string tag);
    int n;
    n = 0;
    bus.if_valid = 1'b0;
    bus.ex_ready = 1'b1;
    while ((sb.size() != 0 || bus.id_valid) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_drain_left"}, 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard: compare on each ID fire, enqueue on each accepted fetch.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.id_valid && bus.ex_ready) begin
        if (sb.size() == 0) begin
          check("fire_unexpected", 32'(bus.id_valid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("id_inst", bus.id_inst, mon_e.inst);
          check("id_pc", bus.id_pc, mon_e.pc);
          check("imm_sel", 32'(bus.imm_sel), 32'(mon_e.imm));
        end
      end
      if (bus.flush) sb.delete();
      else if (bus.if_valid && bus.if_ready) sb.push_back('{bus.if_inst, bus.if_pc, cur_imm});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cyc;
    logic acc;

    rst = 1'b1;
    idle_inputs();
    bus.if_inst = '0;
    bus.if_pc   = '0;
    cur_imm     = 3'd0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_id_valid", 32'(bus.id_valid), 32'd0);
    check("rst_id_stall", 32'(bus.id_stall), 32'd0);
    check("rst_if_ready", 32'(bus.if_ready), 32'd0);
    check("rst_imm_sel", 32'(bus.imm_sel), 32'd3);
    check("rst_id_inst", bus.id_inst, 32'h00000013);
    check("rst_id_pc", bus.id_pc, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    check("post_rst_if_ready", 32'(bus.if_ready), 32'd1);

    // Capacity: ex_ready low, four offers, three accepted, in-order drain
    for (int i = 0; i < 4; i++) begin
      offer(i, 32'h1000 + 32'(4 * i));
      @(negedge clk);
      check("cap_if_ready", 32'(bus.if_ready), 32'(i < 3));
      step();
    end
    bus.if_valid = 1'b0;
    check("cap_count", 32'(dut.fifo_count), 32'd2);
    drain(20, "cap");
    idle_inputs();

    // Load-use hazards
    for (int h = 0; h < 6; h++) begin
      offer(hz_idx[h], 32'h2000 + 32'(16 * h));
      step();
      bus.if_valid   = 1'b0;
      bus.ex_memread = 1'b1;
      bus.ex_rd      = hz_rd[h];
      bus.ex_ready   = 1'b1;
      @(negedge clk);
      check("hz_stall", 32'(bus.id_stall), 32'(hz_st[h]));
      check("hz_valid", 32'(bus.id_valid), 32'(!hz_st[h]));
      check("hz_imm_sel", 32'(bus.imm_sel), 32'(t_imm[hz_idx[h]]));
      if (hz_st[h]) begin
        step();
        @(negedge clk);
        check("hz_resume_valid", 32'(bus.id_valid), 32'd1);
        check("hz_resume_stall", 32'(bus.id_stall), 32'd0);
        check("hz_resume_inst", bus.id_inst, t_inst[hz_idx[h]]);
      end
      step();
      idle_inputs();
      drain(10, "hz");
      idle_inputs();
    end

    // Flush with FIFO and ID full and a fetch offered
    for (int i = 0; i < 3; i++) begin
      offer(8 + i, 32'h3000 + 32'(4 * i));
      step();
    end
    offer(11, 32'h300C);
    bus.flush = 1'b1;
    @(negedge clk);
    check("fl_full_if_ready", 32'(bus.if_ready), 32'd0);
    step();
    idle_inputs();
    @(negedge clk);
    check("fl_id_valid", 32'(bus.id_valid), 32'd0);
    check("fl_count", 32'(dut.fifo_count), 32'd0);
    check("fl_if_ready", 32'(bus.if_ready), 32'd1);
    step();
    bus.ex_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("fl_quiet", 32'(bus.id_valid), 32'd0);
    end
    step();
    idle_inputs();

    // Flush overrides a fetch that would otherwise be accepted
    offer(0, 32'h3100);
    step();
    offer(1, 32'h3104);
    bus.flush = 1'b1;
    @(negedge clk);
    check("fl2_if_ready", 32'(bus.if_ready), 32'd1);
    step();
    idle_inputs();
    bus.ex_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("fl2_quiet", 32'(bus.id_valid), 32'd0);
    end
    check("fl2_count", 32'(dut.fifo_count), 32'd0);
    step();
    idle_inputs();

    // Random streaming with back-pressure and occasional load-use stalls
    k = 0;
    cyc = 0;
    while (k < 24 && cyc < 400) begin
      if (!bus.if_valid && $urandom_range(0, 3) != 0) offer(k % 12, 32'h4000 + 32'(4 * k));
      bus.ex_ready   = 1'($urandom_range(0, 1));
      bus.ex_memread = ($urandom_range(0, 2) == 0);
      bus.ex_rd      = 5'($urandom_range(0, 7));
      @(negedge clk);
      acc = bus.if_valid & bus.if_ready;
      step();
      cyc++;
      if (acc) begin
        bus.if_valid = 1'b0;
        k++;
      end
    end
    check("stream_sent", 32'(k), 32'd24);
    bus.ex_memread = 1'b0;
    drain(80, "stream");
    idle_inputs();

    // Asynchronous reset in the middle of a stall
    offer(5, 32'h5000);
    step();
    bus.if_valid   = 1'b0;
    bus.ex_memread = 1'b1;
    bus.ex_rd      = 5'd5;
    bus.ex_ready   = 1'b1;
    @(negedge clk);
    check("rs_stall", 32'(bus.id_stall), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rs_id_valid", 32'(bus.id_valid), 32'd0);
    check("rs_id_stall", 32'(bus.id_stall), 32'd0);
    check("rs_if_ready", 32'(bus.if_ready), 32'd0);
    check("rs_imm_sel", 32'(bus.imm_sel), 32'd3);
    check("rs_id_inst", bus.id_inst, 32'h00000013);
    check("rs_id_pc", bus.id_pc, 32'd0);
    idle_inputs();
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    check("rs_post_if_ready", 32'(bus.if_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
